// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM states, default widths and helpers.
package cpu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int REG_IDX_W   = 5;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Word accesses must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a completed (or faulting) instruction,
// otherwise presents a bubble so write-back never sees a stale write enable.
module mem_wb_reg import cpu_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_err,
    input  logic                 i_mem_ld,
    input  logic [WIDTH-1:0]     i_exe,
    input  logic [WIDTH-1:0]     i_mem,
    input  logic                 i_mem2reg,
    input  logic                 i_regwrite,
    input  logic [REG_IDX_W-1:0] i_rd,
    output logic [WIDTH-1:0]     o_exe,
    output logic [WIDTH-1:0]     o_mem,
    output logic                 o_mem2reg,
    output logic                 o_regwrite,
    output logic [REG_IDX_W-1:0] o_rd,
    output logic                 o_valid,
    output logic                 o_err
);

    logic [WIDTH-1:0]     r_exe;
    logic [WIDTH-1:0]     r_mem;
    logic                 r_mem2reg;
    logic                 r_regwrite;
    logic [REG_IDX_W-1:0] r_rd;
    logic                 r_valid;
    logic                 r_err;

    // Capture the instruction on load/error; a bubble clears the control bits
    // and keeps the data fields (memOut only changes when a load completes).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exe      <= '0;
            r_mem      <= '0;
            r_mem2reg  <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else if (i_load || i_err) begin
            r_exe      <= i_exe;
            r_mem2reg  <= i_mem2reg;
            r_rd       <= i_rd;
            r_valid    <= 1'b1;
            r_regwrite <= i_regwrite & ~i_err;
            r_err      <= i_err;
            if (i_mem_ld) begin
                r_mem <= i_mem;
            end
        end else begin
            r_mem2reg  <= 1'b0;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end
    end

    assign o_exe      = r_exe;
    assign o_mem      = r_mem;
    assign o_mem2reg  = r_mem2reg;
    assign o_regwrite = r_regwrite;
    assign o_rd       = r_rd;
    assign o_valid    = r_valid;
    assign o_err      = r_err;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues word loads/stores on a req/ack data port,
// stalls upstream while an access is outstanding, and fills MEM/WB.
module mem_access_stage import cpu_pkg::*; #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_alu,
    input  logic [WIDTH-1:0]     in_sdata,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_memread,
    input  logic                 in_memwrite,
    input  logic                 in_mem2reg,
    input  logic                 in_regwrite,
    output logic                 stall_out,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [WIDTH-1:0]     dmem_addr,
    output logic [WIDTH-1:0]     dmem_wdata,
    input  logic [WIDTH-1:0]     dmem_rdata,
    input  logic                 dmem_ack,
    output logic [WIDTH-1:0]     exeOut,
    output logic [WIDTH-1:0]     memOut,
    output logic                 Mem2Reg,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic                 wb_valid,
    output logic                 mem_err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_we;

    logic w_is_mem;
    logic w_misaligned;
    logic w_in_wait;
    logic w_timeout;
    logic w_wb_load;
    logic w_wb_err;
    logic w_wb_mem_ld;

    assign w_is_mem     = in_valid & (in_memread | in_memwrite);
    assign w_misaligned = is_misaligned(in_alu[1:0]);
    assign w_in_wait    = (r_state == WAIT);
    assign w_timeout    = w_in_wait & ~dmem_ack & (r_cnt == CNT_LAST);

    // The instruction leaves MEM in the same cycle its access completes.
    assign stall_out  = w_is_mem & ~w_misaligned & ~(w_in_wait & (dmem_ack | w_timeout));
    assign dmem_req   = w_in_wait;
    assign dmem_we    = r_we & w_in_wait;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

    // State, timeout counter and latched bus request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_wait && !dmem_ack && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (!w_in_wait && w_is_mem && !w_misaligned) begin
                r_addr  <= in_alu;
                r_wdata <= in_sdata;
                r_we    <= in_memwrite;
            end
        end
    end

    // Next state and MEM/WB load/error/bubble selection.
    always_comb begin
        w_next      = r_state;
        w_wb_load   = 1'b0;
        w_wb_err    = 1'b0;
        w_wb_mem_ld = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && !w_is_mem) begin
                    w_wb_load = 1'b1;
                end else if (w_is_mem && w_misaligned) begin
                    w_wb_err = 1'b1;
                end else if (w_is_mem) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    w_wb_load   = 1'b1;
                    w_wb_mem_ld = in_memread;
                    w_next      = IDLE;
                end else if (w_timeout) begin
                    w_wb_err = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    mem_wb_reg #(
        .WIDTH (WIDTH)
    ) u_mem_wb_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_wb_load),
        .i_err      (w_wb_err),
        .i_mem_ld   (w_wb_mem_ld),
        .i_exe      (in_alu),
        .i_mem      (dmem_rdata),
        .i_mem2reg  (in_mem2reg),
        .i_regwrite (in_regwrite),
        .i_rd       (in_rd),
        .o_exe      (exeOut),
        .o_mem      (memOut),
        .o_mem2reg  (Mem2Reg),
        .o_regwrite (RegWrite),
        .o_rd       (wb_rd),
        .o_valid    (wb_valid),
        .o_err      (mem_err)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a MEM/WB scoreboard.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_alu;
    logic [31:0] in_sdata;
    logic [4:0]  in_rd;
    logic        in_memread;
    logic        in_memwrite;
    logic        in_mem2reg;
    logic        in_regwrite;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] exeOut;
    logic [31:0] memOut;
    logic        Mem2Reg;
    logic        RegWrite;
    logic [4:0]  wb_rd;
    logic        wb_valid;
    logic        mem_err;

    mem_access_stage #(
        .WIDTH   (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_alu      (in_alu),
        .in_sdata    (in_sdata),
        .in_rd       (in_rd),
        .in_memread  (in_memread),
        .in_memwrite (in_memwrite),
        .in_mem2reg  (in_mem2reg),
        .in_regwrite (in_regwrite),
        .stall_out   (stall_out),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .exeOut      (exeOut),
        .memOut      (memOut),
        .Mem2Reg     (Mem2Reg),
        .RegWrite    (RegWrite),
        .wb_rd       (wb_rd),
        .wb_valid    (wb_valid),
        .mem_err     (mem_err)
    );

    typedef struct packed {
        logic [31:0] exe;
        logic [31:0] mem;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic        err;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_wb(input logic [31:0] exe, input logic [31:0] mem, input logic m2r,
                             input logic rw, input logic [4:0] rd, input logic err);
        wb_t e;
        e.exe = exe; e.mem = mem; e.m2r = m2r; e.rw = rw; e.rd = rd; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_wb();
        wb_t e;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected_valid", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_exeOut",   exeOut,          e.exe);
                chk("wb_memOut",   memOut,          e.mem);
                chk("wb_Mem2Reg",  32'(Mem2Reg),    32'(e.m2r));
                chk("wb_RegWrite", 32'(RegWrite),   32'(e.rw));
                chk("wb_rd",       32'(wb_rd),      32'(e.rd));
                chk("wb_mem_err",  32'(mem_err),    32'(e.err));
            end
        end else begin
            chk("bubble_RegWrite", 32'(RegWrite), 32'd0);
            chk("bubble_mem_err",  32'(mem_err),  32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_wb();
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic m2r, input logic rw);
        in_valid = v; in_alu = alu; in_sdata = sd; in_rd = rd;
        in_memread = mr; in_memwrite = mw; in_mem2reg = m2r; in_regwrite = rw;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},    32'(stall_out), 32'd0);
        chk({tag, "_req"},      32'(dmem_req),  32'd0);
        chk({tag, "_we"},       32'(dmem_we),   32'd0);
        chk({tag, "_addr"},     dmem_addr,      32'd0);
        chk({tag, "_wdata"},    dmem_wdata,     32'd0);
        chk({tag, "_exeOut"},   exeOut,         32'd0);
        chk({tag, "_memOut"},   memOut,         32'd0);
        chk({tag, "_Mem2Reg"},  32'(Mem2Reg),   32'd0);
        chk({tag, "_RegWrite"}, 32'(RegWrite),  32'd0);
        chk({tag, "_wb_rd"},    32'(wb_rd),     32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid),  32'd0);
        chk({tag, "_mem_err"},  32'(mem_err),   32'd0);
    endtask

    initial begin
        logic [31:0] exp_mem;
        exp_mem    = 32'd0;
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // 1: plain ALU op, one-cycle latency, never stalls
        drive(1'b1, 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("alu_stall", 32'(stall_out), 32'd0);
        chk("alu_req",   32'(dmem_req),  32'd0);
        expect_wb(32'h0000_1234, exp_mem, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: load at 0x100, ack on the third WAIT cycle
        drive(1'b1, 32'h0000_0100, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("ld_accept_stall", 32'(stall_out), 32'd1);
        chk("ld_accept_req",   32'(dmem_req),  32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
                #1;
                exp_mem = 32'hDEAD_BEEF;
                expect_wb(32'h0000_0100, exp_mem, 1'b1, 1'b1, 5'd7, 1'b0);
                chk("ld_ack_stall", 32'(stall_out), 32'd0);
            end else begin
                chk("ld_wait_stall", 32'(stall_out), 32'd1);
            end
            chk("ld_wait_req",  32'(dmem_req), 32'd1);
            chk("ld_wait_we",   32'(dmem_we),  32'd0);
            chk("ld_wait_addr", dmem_addr,     32'h0000_0100);
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ld_done_req",   32'(dmem_req),  32'd0);
        chk("ld_done_stall", 32'(stall_out), 32'd0);
        tick();

        // 3: store at 0x200 with immediate ack
        drive(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("st_accept_stall", 32'(stall_out), 32'd1);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("st_req",   32'(dmem_req),  32'd1);
        chk("st_we",    32'(dmem_we),   32'd1);
        chk("st_addr",  dmem_addr,      32'h0000_0200);
        chk("st_wdata", dmem_wdata,     32'hCAFE_F00D);
        chk("st_stall", 32'(stall_out), 32'd0);
        expect_wb(32'h0000_0200, exp_mem, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("st_done_req", 32'(dmem_req), 32'd0);
        chk("st_done_we",  32'(dmem_we),  32'd0);

        // 4: misaligned load faults without touching the bus
        drive(1'b1, 32'h0000_0103, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mis_stall", 32'(stall_out), 32'd0);
        chk("mis_req",   32'(dmem_req),  32'd0);
        expect_wb(32'h0000_0103, exp_mem, 1'b1, 1'b0, 5'd9, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mis_after_req", 32'(dmem_req), 32'd0);
        tick();

        // 5: load never acked -> timeout after TIMEOUT WAIT cycles, late ack ignored
        drive(1'b1, 32'h0000_0300, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("to_accept_stall", 32'(stall_out), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_req", 32'(dmem_req), 32'd1);
            if (i == 3) begin
                chk("to_last_stall", 32'(stall_out), 32'd0);
                expect_wb(32'h0000_0300, exp_mem, 1'b1, 1'b0, 5'd3, 1'b1);
            end else begin
                chk("to_wait_stall", 32'(stall_out), 32'd1);
            end
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_drop_req", 32'(dmem_req), 32'd0);
        tick();
        chk("to_late_ack_memOut", memOut, exp_mem);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;

        // 6: reset during the second WAIT cycle abandons the access
        drive(1'b1, 32'h0000_0400, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rst_wait1_req", 32'(dmem_req), 32'd1);
        tick();
        chk("rst_wait2_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all_zero("wait_reset");
        exp_mem  = 32'd0;
        reset    = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h3333_4444;
        #1;
        chk("rst_late_ack_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk("rst_late_ack_memOut", memOut, 32'd0);
        drive(1'b1, 32'h0000_5678, 32'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_stall", 32'(stall_out), 32'd0);
        expect_wb(32'h0000_5678, exp_mem, 1'b0, 1'b1, 5'd6, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
